// File: rtl/adc_sched.sv
// adc_sched: periodic multi-channel ADC sweep scheduler.
// A period timer produces ticks. Each accepted tick starts one sweep over
// channels 0..num_ch. Each channel is converted by the SPI engine
// (spi_start/spi_done) and then handed to the SPI-to-FIFO stage with a
// four-phase fs/fd handshake. Ticks that arrive mid-sweep are dropped and
// reported through the sticky overrun flag.
module adc_sched #(
    parameter int CH_W  = 5,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    input  logic [CH_W-1:0]  num_ch,
    input  logic             clr_ovr,
    output logic             spi_start,
    output logic [CH_W-1:0]  spi_ch,
    input  logic             spi_done,
    output logic             fs,
    input  logic             fd,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        CONV      = 3'd3,
        XFER      = 3'd4,
        REL       = 3'd5,
        NEXT      = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PER_W-1:0] eff_period_s;
    logic [PER_W-1:0] tcnt_r;
    logic             tick_r;
    logic             last_ch_s;

    // The channel under transfer is the last one of the sweep.
    assign last_ch_s = (spi_ch == num_ch);

    // Clamp the period: 0 and 1 would give a degenerate timer, run them as 2.
    always_comb begin
        if (period < PER_W'(2)) begin
            eff_period_s = PER_W'(2);
        end else begin
            eff_period_s = period;
        end
    end

    // Period timer; the >= compare also recovers when period shrinks below tcnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= '0;
            tick_r <= 1'b0;
        end else if (!enable) begin
            tcnt_r <= '0;
            tick_r <= 1'b0;
        end else if (tcnt_r >= (eff_period_s - PER_W'(1))) begin
            tcnt_r <= '0;
            tick_r <= 1'b1;
        end else begin
            tcnt_r <= tcnt_r + PER_W'(1);
            tick_r <= 1'b0;
        end
    end

    // Sweep sequencing: next-state selection from the registered state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt_s = WAIT_TICK;
                else        state_nxt_s = IDLE;
            end
            WAIT_TICK: begin
                if (!enable)     state_nxt_s = IDLE;
                else if (tick_r) state_nxt_s = START;
                else             state_nxt_s = WAIT_TICK;
            end
            START: state_nxt_s = CONV;
            CONV: begin
                if (spi_done) state_nxt_s = XFER;
                else          state_nxt_s = CONV;
            end
            XFER: begin
                if (fd) state_nxt_s = REL;
                else    state_nxt_s = XFER;
            end
            REL: begin
                if (!fd) state_nxt_s = NEXT;
                else     state_nxt_s = REL;
            end
            NEXT: begin
                if (!last_ch_s)  state_nxt_s = START;
                else if (enable) state_nxt_s = WAIT_TICK;
                else             state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            spi_start  <= 1'b0;
            fs         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            spi_ch     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            spi_start  <= (state_nxt_s == START);
            fs         <= (state_nxt_s == XFER);
            busy       <= !((state_nxt_s == IDLE) || (state_nxt_s == WAIT_TICK));
            frame_done <= (state_r == NEXT) && last_ch_s;
            if ((state_r == NEXT) && last_ch_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((state_r == WAIT_TICK) && (state_nxt_s == START)) begin
                spi_ch <= '0;
            end else if (state_r == NEXT) begin
                spi_ch <= last_ch_s ? '0 : (spi_ch + CH_W'(1));
            end
        end
    end

    // Sticky overrun: a tick outside WAIT_TICK sets it and beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (tick_r && (state_r != WAIT_TICK)) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sched.sv
// tb_adc_sched: directed scenario bench for adc_sched.
// A responder answers spi_start with spi_done one cycle later and mirrors
// fs onto fd (optionally stretching fd); a monitor logs starts, fs rises
// and frame_done pulses. Each scenario task checks hand-derived timings.
module tb_adc_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic [4:0]  num_ch;
    logic        clr_ovr;
    logic        spi_start;
    logic [4:0]  spi_ch;
    logic        spi_done;
    logic        fs;
    logic        fd;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // responder controls
    logic resp_en   = 1'b1;
    logic force_fd  = 1'b0;
    int   fd_extra  = 0;

    // monitor log
    logic [4:0] mon_starts[$];
    int mon_fs_rises   = 0;
    int mon_frames     = 0;
    int mon_start_fd   = 0;
    int mon_overlap    = 0;

    adc_sched #(.CH_W(5), .PER_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .num_ch(num_ch),
        .clr_ovr(clr_ovr), .spi_start(spi_start), .spi_ch(spi_ch), .spi_done(spi_done),
        .fs(fs), .fd(fd), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic responder();
        logic start_prev = 1'b0;
        int   hold = 0;
        fd = 1'b0;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                spi_done = start_prev;
                start_prev = spi_start;
                if (fs) begin
                    fd = 1'b1;
                    hold = fd_extra;
                end else if (hold > 0) begin
                    hold--;
                    fd = 1'b1;
                end else begin
                    fd = 1'b0;
                end
            end else begin
                fd = force_fd;
                spi_done = 1'b0;
                start_prev = 1'b0;
                hold = 0;
            end
        end
    endtask

    task automatic monitor();
        logic fs_prev = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (spi_start) begin
                    mon_starts.push_back(spi_ch);
                    if (fd) mon_start_fd++;
                    if (fs) mon_overlap++;
                end
                if (fs && !fs_prev) mon_fs_rises++;
                if (frame_done) mon_frames++;
            end
            fs_prev = fs;
        end
    endtask

    task automatic wait_start(output int cyc);
        logic found = 1'b0;
        cyc = 0;
        while (!found && cyc < 300) begin
            @(negedge clk); cyc++;
            found = (spi_start === 1'b1);
        end
        if (!found) begin
            total_cnt++;
            $display("FAIL wait_start: no spi_start within %0d cycles", cyc);
            cyc = -1;
        end
    endtask

    task automatic wait_frame(output int cyc);
        logic found = 1'b0;
        cyc = 0;
        while (!found && cyc < 300) begin
            @(negedge clk); cyc++;
            found = (frame_done === 1'b1);
        end
        if (!found) begin
            total_cnt++;
            $display("FAIL wait_frame: no frame_done within %0d cycles", cyc);
            cyc = -1;
        end
    endtask

    task automatic wait_fs(output int cyc);
        logic found = 1'b0;
        cyc = 0;
        while (!found && cyc < 300) begin
            @(negedge clk); cyc++;
            found = (fs === 1'b1);
        end
        if (!found) begin
            total_cnt++;
            $display("FAIL wait_fs: no fs within %0d cycles", cyc);
            cyc = -1;
        end
    endtask

    task automatic wait_idle(output int cyc);
        logic found = 1'b0;
        cyc = 0;
        while (!found && cyc < 300) begin
            @(negedge clk); cyc++;
            found = (busy === 1'b0);
        end
        if (!found) begin
            total_cnt++;
            $display("FAIL wait_idle: busy still high after %0d cycles", cyc);
            cyc = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; clr_ovr = 1'b0; period = 16'd10; num_ch = 5'd0;
        resp_en = 1'b1; fd_extra = 0; force_fd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; period = 16'd10; num_ch = 5'd0; clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (spi_start !== 1'b0) $display("FAIL rst_spi_start: got %b expected 0", spi_start); else pass_cnt++;
        total_cnt++; if (fs !== 1'b0) $display("FAIL rst_fs: got %b expected 0", fs); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++; if (spi_ch !== 5'd0) $display("FAIL rst_spi_ch: got %0d expected 0", spi_ch); else pass_cnt++;
        enable = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_enable_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (mon_starts.size() !== 0) $display("FAIL idle_no_enable_starts: got %0d expected 0", mon_starts.size()); else pass_cnt++;
    endtask

    task automatic test_single_sweep();
        int c;
        int f0;
        int p0;
        do_reset();
        period = 16'd10; num_ch = 5'd0;
        f0 = mon_fs_rises; p0 = mon_frames;
        enable = 1'b1;
        wait_start(c);
        total_cnt++; if (c !== 11) $display("FAIL single_first_start: got %0d expected 11", c); else pass_cnt++;
        total_cnt++; if (spi_ch !== 5'd0) $display("FAIL single_ch: got %0d expected 0", spi_ch); else pass_cnt++;
        wait_frame(c);
        total_cnt++; if (c !== 5) $display("FAIL single_latency: got %0d expected 5", c); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
        total_cnt++; if (mon_fs_rises - f0 !== 1) $display("FAIL single_fs_handshakes: got %0d expected 1", mon_fs_rises - f0); else pass_cnt++;
        wait_start(c);
        total_cnt++; if (c !== 5) $display("FAIL single_repeat_start: got %0d expected 5", c); else pass_cnt++;
        wait_frame(c);
        total_cnt++; if (frame_cnt !== 16'd2) $display("FAIL single_frame_cnt2: got %0d expected 2", frame_cnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mon_frames - p0 !== 2) $display("FAIL single_frame_pulses: got %0d expected 2", mon_frames - p0); else pass_cnt++;
    endtask

    task automatic test_period_min();
        int c;
        do_reset();
        period = 16'd0; num_ch = 5'd0;
        enable = 1'b1;
        wait_start(c);
        total_cnt++; if (c !== 3) $display("FAIL period0_first_start: got %0d expected 3", c); else pass_cnt++;
        wait_frame(c);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL period0_overrun: got %b expected 1", overrun); else pass_cnt++;
    endtask

    task automatic test_multi_channel();
        int c;
        int s0;
        int f0;
        int p0;
        do_reset();
        period = 16'd30; num_ch = 5'd3;
        s0 = mon_starts.size(); f0 = mon_fs_rises; p0 = mon_frames;
        enable = 1'b1;
        wait_frame(c);
        total_cnt++; if (c !== 51) $display("FAIL multi_frame_time: got %0d expected 51", c); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mon_starts.size() - s0 !== 4) $display("FAIL multi_start_count: got %0d expected 4", mon_starts.size() - s0); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (s0 + i < mon_starts.size()) begin
                total_cnt++;
                if (mon_starts[s0 + i] !== 5'(i)) $display("FAIL multi_ch_order[%0d]: got %0d expected %0d", i, mon_starts[s0 + i], i);
                else pass_cnt++;
            end
        end
        total_cnt++; if (mon_fs_rises - f0 !== 4) $display("FAIL multi_fs_handshakes: got %0d expected 4", mon_fs_rises - f0); else pass_cnt++;
        total_cnt++; if (mon_frames - p0 !== 1) $display("FAIL multi_frame_pulses: got %0d expected 1", mon_frames - p0); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL multi_frame_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL multi_no_overrun: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int c;
        int s0;
        do_reset();
        period = 16'd4; num_ch = 5'd3;
        s0 = mon_starts.size();
        enable = 1'b1;
        wait_start(c);
        total_cnt++; if (c !== 5) $display("FAIL ovr_first_start: got %0d expected 5", c); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_before_tick: got %b expected 0", overrun); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else pass_cnt++;
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else pass_cnt++;
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b expected 1", overrun); else pass_cnt++;
        wait_frame(c);
        total_cnt++; if (c !== 12) $display("FAIL ovr_frame_time: got %0d expected 12", c); else pass_cnt++;
        total_cnt++; if (mon_starts.size() - s0 !== 4) $display("FAIL ovr_no_extra_sweep: got %0d expected 4", mon_starts.size() - s0); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (spi_start !== 1'b1) $display("FAIL ovr_next_on_tick: got %b expected 1", spi_start); else pass_cnt++;
        enable = 1'b0;
        wait_idle(c);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else pass_cnt++;
        clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_idle_clear: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_fd_hold();
        int c;
        int f0;
        int sf0;
        do_reset();
        period = 16'd40; num_ch = 5'd1; fd_extra = 5;
        f0 = mon_fs_rises; sf0 = mon_start_fd;
        enable = 1'b1;
        wait_start(c);
        wait_start(c);
        total_cnt++; if (c !== 10) $display("FAIL fd_hold_gap: got %0d expected 10", c); else pass_cnt++;
        total_cnt++; if (mon_fs_rises - f0 !== 1) $display("FAIL fd_hold_fs_count: got %0d expected 1", mon_fs_rises - f0); else pass_cnt++;
        total_cnt++; if (mon_start_fd - sf0 !== 0) $display("FAIL fd_hold_start_during_fd: got %0d expected 0", mon_start_fd - sf0); else pass_cnt++;
        enable = 1'b0;
        fd_extra = 0;
    endtask

    task automatic test_enable_drop();
        int c;
        int s0;
        int p0;
        do_reset();
        period = 16'd40; num_ch = 5'd2;
        s0 = mon_starts.size(); p0 = mon_frames;
        enable = 1'b1;
        wait_start(c);
        wait_start(c);
        total_cnt++; if (spi_ch !== 5'd1) $display("FAIL drop_ch1: got %0d expected 1", spi_ch); else pass_cnt++;
        @(negedge clk);
        enable = 1'b0;
        wait_frame(c);
        total_cnt++; if (c !== 9) $display("FAIL drop_frame_time: got %0d expected 9", c); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL drop_idle_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL drop_frame_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
        repeat (60) @(negedge clk);
        total_cnt++; if (mon_starts.size() - s0 !== 3) $display("FAIL drop_start_count: got %0d expected 3", mon_starts.size() - s0); else pass_cnt++;
        if (mon_starts.size() - s0 >= 3) begin
            total_cnt++;
            if (mon_starts[s0 + 2] !== 5'd2) $display("FAIL drop_last_ch: got %0d expected 2", mon_starts[s0 + 2]);
            else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL drop_stays_idle: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (mon_frames - p0 !== 1) $display("FAIL drop_frame_pulses: got %0d expected 1", mon_frames - p0); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int c;
        int c2;
        do_reset();
        period = 16'd10; num_ch = 5'd0;
        enable = 1'b1;
        wait_frame(c);
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL rstmid_pre_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
        wait_fs(c);
        total_cnt++; if (c !== 7) $display("FAIL rstmid_fs_time: got %0d expected 7", c); else pass_cnt++;
        resp_en = 1'b0; force_fd = 1'b1;
        rst = 1'b1;
        #1;
        total_cnt++; if (fs !== 1'b0) $display("FAIL rstmid_fs_async: got %b expected 0", fs); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || fs !== 1'b0) $display("FAIL rstmid_restart_idle: got busy=%b fs=%b expected 0 0", busy, fs); else pass_cnt++;
        resp_en = 1'b1; force_fd = 1'b0;
        wait_start(c2);
        total_cnt++; if (3 + c2 !== 11) $display("FAIL rstmid_restart_period: got %0d expected 11", 3 + c2); else pass_cnt++;
        wait_frame(c);
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL rstmid_post_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
        enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; period = 16'd10; num_ch = 5'd0; clr_ovr = 1'b0;
        fork
            responder();
            monitor();
        join_none
        test_reset();
        test_single_sweep();
        test_period_min();
        test_multi_channel();
        test_overrun();
        test_fd_hold();
        test_enable_drop();
        test_rst_mid();
        total_cnt++; if (mon_overlap !== 0) $display("FAIL fs_start_overlap: got %0d expected 0", mon_overlap); else pass_cnt++;
        total_cnt++; if (mon_start_fd !== 0) $display("FAIL start_while_fd: got %0d expected 0", mon_start_fd); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_sched.md
ADC_SCHED -- requirements
Module: adc_sched

Interface
REQ-001 Parameter CH_W, default 5: width of the channel index; up to 2^CH_W channels per sweep.
REQ-002 Parameter PER_W, default 16: width of the sample-period timer.
REQ-003 clk  input  1  system clock; the same clock domain as the SPI-to-FIFO stage (fifo_txc).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  level; when high, periodic sweeps run.
REQ-006 period  input  PER_W  sample period in clk cycles; sampled every cycle; values 0 and 1 are treated as 2.
REQ-007 num_ch  input  CH_W  channels per sweep minus 1 (0 means 1 channel).
REQ-008 clr_ovr  input  1  one-cycle pulse that clears the overrun flag.
REQ-009 spi_start  output  1  one-cycle pulse that starts a conversion on channel spi_ch.
REQ-010 spi_ch  output  CH_W  current channel index; stable from spi_start until the transfer completes.
REQ-011 spi_done  input  1  conversion complete; chip_rxda/chip_rxdb are valid while it is high.
REQ-012 fs  output  1  frame-start request to the SPI-to-FIFO stage.
REQ-013 fd  input  1  frame-done acknowledge from the SPI-to-FIFO stage.
REQ-014 busy  output  1  high in every state except IDLE and WAIT_TICK.
REQ-015 frame_done  output  1  one-cycle pulse when a sweep of all channels completes.
REQ-016 frame_cnt  output  16  number of completed sweeps; wraps from 0xFFFF to 0.
REQ-017 overrun  output  1  sticky flag: a timer tick arrived while a sweep was in progress.

Function
REQ-018 Timer: counter tcnt increments every cycle while enable=1; when tcnt == eff_period-1, the block SHALL assert tick for one cycle and set tcnt to 0; tcnt SHALL be held at 0 while enable=0.
REQ-019 FSM states: IDLE, WAIT_TICK, START, CONV, XFER, REL, NEXT; all outputs are decoded from the registered state (Moore).
REQ-020 IDLE: if enable=1, go to WAIT_TICK next cycle; otherwise stay.
REQ-021 WAIT_TICK: if enable=0, go to IDLE; else on tick go to START with spi_ch=0; else stay.
REQ-022 START: spi_start=1 for exactly this one cycle; unconditionally go to CONV.
REQ-023 CONV: wait for spi_done=1, then go to XFER; spi_done is ignored in all other states.
REQ-024 XFER: fs=1; on fd=1 go to REL.
REQ-025 REL: fs=0; wait for fd=0 (four-phase handshake), then go to NEXT.
REQ-026 NEXT, when spi_ch == num_ch: pulse frame_done, increment frame_cnt, clear spi_ch, and go to WAIT_TICK (or IDLE if enable=0).
REQ-027 NEXT, when spi_ch != num_ch: increment spi_ch and go to START.
REQ-028 Minimum per-channel latency from START to NEXT is 4 cycles when spi_done and fd respond immediately.
REQ-029 A tick in any state other than WAIT_TICK SHALL set overrun; the tick is dropped and does not queue a sweep.
REQ-030 If clr_ovr and an overrun-setting tick occur in the same cycle, set wins.
REQ-031 Deasserting enable mid-sweep SHALL NOT abort the sweep; it completes, then the FSM enters IDLE.
REQ-032 num_ch and period changes take effect immediately; num_ch is compared in NEXT only.
REQ-033 fs SHALL never be high while spi_start is high; fs is deasserted before the next spi_start.
REQ-034 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-035 During and after reset: state=IDLE, tcnt=0, spi_ch=0, frame_cnt=0, overrun=0; spi_start, fs, busy and frame_done all 0.
REQ-036 Reset asserted mid-handshake (fs=1) SHALL drop fs asynchronously; after release, the block restarts from IDLE regardless of fd.

Verification
REQ-037 enable=1, period=10, num_ch=0, spi_done and fd responding in 1 cycle -> first spi_start 10 cycles after WAIT_TICK entry, one fs/fd handshake, frame_done pulse, frame_cnt=1, then repeats every 10 cycles.
REQ-038 num_ch=3 -> spi_start issued with spi_ch=0,1,2,3 in order, four fs handshakes, exactly one frame_done per sweep.
REQ-039 period=4, num_ch=3 (sweep longer than the period) -> overrun=1 after the first mid-sweep tick; no extra sweep starts; clr_ovr pulse -> overrun=0.
REQ-040 fd held high for 5 cycles after fs -> FSM stays in REL and no spi_start is issued until fd=0.
REQ-041 enable dropped during CONV on channel 1 of num_ch=2 -> channels 1 and 2 complete, frame_done pulses, then IDLE with busy=0.
REQ-042 rst pulsed while fs=1 -> fs=0 immediately, frame_cnt=0; with enable=1 a new sweep starts one full period after release.
